// File: rtl/controle_rega.sv
// Irrigation controller: moisture/rain/tank-driven FSM with tick-based timers,
// one-cycle J/K pulses for an external valve JK flip-flop and a saturating cycle counter.
module controle_rega #(
  parameter int TEMPO_REGA  = 8,
  parameter int TEMPO_PAUSA = 4,
  parameter int TICK_DIV    = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Habilita,
  input  logic [1:0] Umidade,
  input  logic       Chuva,
  input  logic       NivelBaixo,
  output logic       J,
  output logic       K,
  output logic [1:0] Estado,
  output logic       Alarme,
  output logic [3:0] Ciclos
);

  typedef enum logic [1:0] {
    OCIOSO  = 2'b00,
    REGANDO = 2'b01,
    PAUSA   = 2'b10,
    FALHA   = 2'b11
  } state_t;

  state_t     r_state, w_next;
  logic [7:0] r_presc, r_timer;
  logic       r_j, r_k, r_alarme;
  logic [3:0] r_ciclos;
  logic       w_demanda, w_tick, w_expira, w_conta;

  assign w_demanda = Habilita && !Umidade[1] && !Chuva;
  assign w_tick    = (r_presc == 8'(TICK_DIV - 1));
  assign w_expira  = w_tick && (r_timer == 8'd1);

  always_comb begin
    w_next  = r_state;
    w_conta = 1'b0;
    case (r_state)
      OCIOSO:
        if (w_demanda) w_next = NivelBaixo ? FALHA : REGANDO;
      REGANDO:
        if (NivelBaixo)                        w_next = FALHA;
        else if (!Habilita)                    w_next = OCIOSO;
        else if ((Umidade == 2'b11) || Chuva)  w_next = PAUSA;
        else if (w_expira) begin
          w_next  = PAUSA;
          w_conta = 1'b1;
        end
      PAUSA:
        if (!Habilita)     w_next = OCIOSO;
        else if (w_expira) w_next = OCIOSO;
      FALHA:
        if (!NivelBaixo) w_next = PAUSA;
      default: w_next = OCIOSO;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_state  <= OCIOSO;
      r_presc  <= 8'd0;
      r_timer  <= 8'd0;
      r_j      <= 1'b0;
      r_k      <= 1'b0;
      r_alarme <= 1'b0;
      r_ciclos <= 4'd0;
    end else begin
      r_state  <= w_next;
      r_j      <= (w_next == REGANDO) && (r_state != REGANDO);
      r_k      <= (r_state == REGANDO) && (w_next != REGANDO);
      r_alarme <= (w_next == FALHA);
      if (w_conta && (r_ciclos != 4'hF)) r_ciclos <= r_ciclos + 4'd1;
      // Every state entry restarts the time base so durations are exact.
      if (w_next != r_state) begin
        r_presc <= 8'd0;
        r_timer <= (w_next == REGANDO) ? 8'(TEMPO_REGA) :
                   (w_next == PAUSA)   ? 8'(TEMPO_PAUSA) : 8'd0;
      end else if ((r_state == REGANDO) || (r_state == PAUSA)) begin
        if (w_tick) begin
          r_presc <= 8'd0;
          r_timer <= r_timer - 8'd1;
        end else begin
          r_presc <= r_presc + 8'd1;
        end
      end
    end
  end

  assign J      = r_j;
  assign K      = r_k;
  assign Estado = r_state;
  assign Alarme = r_alarme;
  assign Ciclos = r_ciclos;

endmodule

// File: doc/controle_rega.md
CONTROLE_REGA -- requirements
Module: controle_rega

Interface
REQ-001 SHALL provide parameter TEMPO_REGA, default 8, irrigation duration in ticks; legal range 1..255.
REQ-002 SHALL provide parameter TEMPO_PAUSA, default 4, minimum pause after irrigation in ticks; legal range 1..255.
REQ-003 SHALL provide parameter TICK_DIV, default 4, Clk cycles per tick; legal range 1..255.
REQ-004 SHALL provide port Clk, input, 1, single clock; all state changes on its rising edge.
REQ-005 SHALL provide port Reset, input, 1, synchronous, active-low reset.
REQ-006 SHALL provide port Habilita, input, 1, system enable.
REQ-007 SHALL provide port Umidade, input, 2, soil moisture: 00 dry, 01 low, 10 ok, 11 saturated.
REQ-008 SHALL provide port Chuva, input, 1, rain detected.
REQ-009 SHALL provide port NivelBaixo, input, 1, water tank low.
REQ-010 SHALL provide port J, output, 1, set command to downstream valve JK flip-flop.
REQ-011 SHALL provide port K, output, 1, clear command to downstream valve JK flip-flop.
REQ-012 SHALL provide port Estado, output, 2, current FSM state code.
REQ-013 SHALL provide port Alarme, output, 1, tank-low fault indication.
REQ-014 SHALL provide port Ciclos, output, 4, count of irrigations completed by timer expiry.

Function
REQ-015 SHALL implement FSM states OCIOSO=00, REGANDO=01, PAUSA=10, FALHA=11; Estado SHALL equal the registered state.
REQ-016 SHALL define demand = Habilita AND Umidade<=01 AND NOT Chuva, sampled at each rising edge.
REQ-017 OCIOSO: demand AND NOT NivelBaixo -> REGANDO; demand AND NivelBaixo -> FALHA; otherwise stay.
REQ-018 REGANDO exit priority, highest first: NivelBaixo -> FALHA; NOT Habilita -> OCIOSO; Umidade=11 OR Chuva -> PAUSA; timer expiry -> PAUSA with Ciclos increment.
REQ-019 PAUSA: NOT Habilita -> OCIOSO immediately; else timer expiry -> OCIOSO; NivelBaixo ignored in PAUSA.
REQ-020 FALHA: NivelBaixo=0 -> PAUSA; otherwise stay regardless of Habilita.
REQ-021 Prescaler: counts 0..TICK_DIV-1; a tick occurs at an edge where prescaler=TICK_DIV-1, and the prescaler wraps to 0 on that edge.
REQ-022 On every state entry, the prescaler SHALL clear to 0 and the 8-bit timer SHALL load TEMPO_REGA (REGANDO) or TEMPO_PAUSA (PAUSA).
REQ-023 Timer SHALL decrement on each tick; expiry = tick while timer=1, so REGANDO and PAUSA each last exactly TEMPO*TICK_DIV cycles absent earlier exits.
REQ-024 J and K SHALL be registered one-cycle pulses; J=1 in the first cycle Estado=01; K=1 in the first cycle after leaving REGANDO.
REQ-025 J and K SHALL never both be 1; neither SHALL pulse on transitions not entering or leaving REGANDO.
REQ-026 Alarme SHALL equal 1 exactly while Estado=11.
REQ-027 Ciclos SHALL saturate at 15; early exits (moisture, rain, disable, fault) SHALL NOT increment it.
REQ-028 From PAUSA to OCIOSO with demand still present, REGANDO re-entry SHALL occur on the next edge (one OCIOSO cycle).

Reset
REQ-029 Reset=0 at a rising edge SHALL force Estado=00, J=0, K=0, Alarme=0, Ciclos=0, prescaler=0, timer=0, overriding all other inputs.
REQ-030 Reset mid-REGANDO SHALL NOT emit a K pulse; downstream valve flip-flop is reset jointly.

Verification (defaults TEMPO_REGA=8, TEMPO_PAUSA=4, TICK_DIV=4)
REQ-031 Reset=0 two cycles with random inputs -> Estado=00, J=K=0, Alarme=0, Ciclos=0.
REQ-032 Habilita=1, Umidade=00, Chuva=0, NivelBaixo=0 -> one-cycle J with Estado=01; 32 cycles later K=1, Estado=10, Ciclos=1; 16 cycles later Estado=00; next cycle J again.
REQ-033 Umidade=11 driven 10 cycles into REGANDO -> next edge Estado=10, K=1 one cycle, Ciclos unchanged.
REQ-034 NivelBaixo=1 during REGANDO -> Estado=11, K=1 one cycle, Alarme=1; NivelBaixo=0 -> Estado=10, Alarme=0, no J.
REQ-035 Chuva=1 with Umidade=00 in OCIOSO for 50 cycles -> Estado stays 00, J never asserted.
REQ-036 17 full irrigations -> Ciclos reads 15 and stays 15.
